uart_fifo_bridge: RTL
=====================

# uart_fifo_bridge

Parametrised UART buffering block: the existing `uart` core, a depth-configurable RX FIFO and TX FIFO, and a forwarding/launch controller between them. In loopback mode, every received byte is echoed back on `tx` without host involvement. In host mode, the FIFOs are exposed to a local push/pop port. It also reports occupancy and sticky overrun status, and is the drop-in successor for the fixed 8-bit loopback top.

## Interface
- `RX_DEPTH`, 16: RX FIFO entries, power of two, ≥2
- `TX_DEPTH`, 16: TX FIFO entries, power of two, ≥2
- `clk`  in  1  system clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `rx`  in  1  UART serial input
- `tx`  out  1  UART serial output, idle high
- `mode`  in  1  1 = loopback, 0 = host
- `host_wdata`  in  8  byte to transmit (host mode)
- `host_wr`  in  1  push `host_wdata` into TX FIFO
- `host_full`  out  1  TX FIFO full
- `host_rdata`  out  8  RX FIFO head, valid while `host_empty`=0
- `host_rd`  in  1  pop RX FIFO head
- `host_empty`  out  1  RX FIFO empty
- `rx_count`  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- `tx_count`  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- `rx_overrun`  out  1  sticky: a received byte was dropped
- `clear`  in  1  synchronous clear of `rx_overrun` and `drop_cnt`
- `drop_cnt`  out  8  dropped-byte counter (see Configuration)

## Operation
- **FIFOs**: first-word-fall-through; head is combinational from storage.
  - Push on full without same-cycle pop is ignored.
  - Pop on empty is ignored.
  - Simultaneous push+pop: both occur, count unchanged. On empty, push only.
  - Pointers wrap modulo DEPTH; count saturates neither way (it is exact).
- **RX path**: `rx_done` pushes `rx_data` into the RX FIFO.
  - If the RX FIFO is full and no pop happens that cycle, the byte is dropped, `rx_overrun` is set, and `drop_cnt` increments.
- **Forwarding** (mode=1): each cycle, RX non-empty AND TX not full → pop RX and push its head into TX in the same cycle.
  - `host_wr`/`host_rd` are ignored; `host_*` status outputs stay live.
- **Host mode** (mode=0): forwarding disabled.
  - `host_wr` pushes TX; `host_rd` pops RX.
  - `mode` is sampled every cycle; a change takes effect the next cycle with no data loss, since forwarding is single-cycle and atomic.
- **TX launch FSM**: states `TX_IDLE`, `TX_START`, `TX_WAIT_BUSY`, `TX_WAIT_DONE`.
  - `TX_IDLE`: TX non-empty AND `tx_busy`=0 → register head into `tx_data_q`, pop TX, go to `TX_START`.
  - `TX_START`: `tx_start`=1 for exactly one cycle → `TX_WAIT_BUSY`.
  - `TX_WAIT_BUSY`: stay until `tx_busy`=1 → `TX_WAIT_DONE`.
  - `TX_WAIT_DONE`: stay until `tx_busy`=0 → `TX_IDLE`.
  - `tx_data_q` is held stable from `TX_START` until the return to `TX_IDLE`.
- **`clear`**: the same cycle as an overrun → clear wins; the overrun is not recorded.

## Timing
- **Reset values**: FIFOs empty, counts 0, `host_empty`=1, `host_full`=0, `rx_overrun`=0, `drop_cnt`=0, FSM `TX_IDLE`, `tx_start`=0, `tx_data_q`=0, `tx`=1.
- **Loopback latency**, with `rx_done` in cycle 0:
  - RX occupied in cycle 1.
  - Forward in cycle 1; TX occupied in cycle 2.
  - Launch decision in cycle 2; `tx_start` high in cycle 3.
- `host_wr` in cycle 0 with the TX FIFO empty and the UART idle → `tx_start` in cycle 2.
- **Back-to-back bytes**: the next launch is no earlier than one cycle after `tx_busy` falls.
- **Reset mid-frame**: all state clears immediately; queued bytes are lost; `tx` returns high per the `uart` reset.

## Configuration
- **`UART_FIFO_DROPCNT_EN` defined**: `drop_cnt` is an 8-bit counter.
  - Increments once per dropped RX byte and saturates at 255.
  - Cleared by `clear` or reset.
- **Undefined**: `drop_cnt` is tied to 0 and no counter logic is generated; `rx_overrun` behaves identically in both cases.

## Structure
- **Shared package `uart_fifo_pkg`**:
  - TX FSM state enum (2-bit encoding, `TX_IDLE`=0).
  - Byte width constant `UART_DW`=8.
  - `MODE_HOST`/`MODE_LOOPBACK` constants.
- **Sub-module `sync_fifo`**: parameters DEPTH and WIDTH; ports push, pop, w_data, r_data, full, empty, count. Instantiated twice.
- The `uart` core is instantiated unchanged.

## Test plan
- **Reset**: hold `rst`=0 for 5 cycles → all outputs at reset values, `tx`=1, no `tx_start`.
- **Loopback echo**: mode=1, serialise 0xA5 then 0x3C on `rx` → `tx` emits 0xA5 then 0x3C; exactly 3 cycles from `rx_done` to `tx_start` for the first byte.
- **Host TX fill** (TX_DEPTH=16): mode=0, push 17 bytes 0x00..0x10 with the UART busy → `host_full` after the 16th; the 17th is ignored; `tx` emits 0x00..0x0F in order.
- **Overrun**: mode=0, no `host_rd`, receive 17 bytes → `rx_count`=16, `rx_overrun`=1, `drop_cnt`=1 (macro on) or 0 (macro off); `clear` → both 0.
- **Simultaneous push/pop on full RX**: `rx_done` coincident with `host_rd` → `rx_count` stays 16, no overrun, head advances.
- **Mode switch under traffic**: toggle mode 1→0 between two received bytes → the first is echoed, the second stays in the RX FIFO and is readable via `host_rdata`.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART FIFO bridge.
package uart_fifo_pkg;

    localparam int   UART_DW       = 8;
    localparam logic MODE_HOST     = 1'b0;
    localparam logic MODE_LOOPBACK = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         w_data,
    output logic [WIDTH-1:0]         r_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign r_data = mem_q[rd_ptr_q];
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= w_data;
    end

    // Pointers wrap naturally at the power-of-two depth; count is exact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART core: one-shot transmitter and mid-bit sampling receiver.
module uart
    import uart_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic               tx,
    input  logic               tx_start,
    input  logic [UART_DW-1:0] tx_data,
    output logic               tx_busy,
    output logic               rx_done,
    output logic [UART_DW-1:0] rx_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [9:0]         tx_shift_q;
    logic [3:0]         tx_bit_q, rx_bit_q;
    logic [CW-1:0]      tx_cnt_q, rx_cnt_q;
    logic               tx_busy_q, rx_busy_q, rx_done_q, rx_s1_q, rx_s2_q;
    logic [UART_DW-1:0] rx_shift_q;

    assign tx      = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign tx_busy = tx_busy_q;
    assign rx_done = rx_done_q;
    assign rx_data = rx_shift_q;

    // Transmitter: shift out start, 8 data bits LSB first, stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
        end else if (!tx_busy_q) begin
            if (tx_start) begin
                tx_shift_q <= {1'b1, tx_data, 1'b0};
                tx_busy_q  <= 1'b1;
                tx_cnt_q   <= CW'(CLKS_PER_BIT - 1);
                tx_bit_q   <= '0;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
        end else begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_bit_q   <= tx_bit_q + 1'b1;
            tx_cnt_q   <= CW'(CLKS_PER_BIT - 1);
        end
    end

    // Receiver: synchronise, find start edge, sample each bit at its centre.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_bit_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_done_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= CW'(CLKS_PER_BIT / 2 - 1);
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= CW'(CLKS_PER_BIT - 1);
                rx_bit_q <= rx_bit_q + 1'b1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_busy_q <= 1'b0;   // glitch, not a start bit
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_done_q <= rx_s2_q;             // only framed bytes count
                end else begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[UART_DW-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART with RX/TX FIFOs, loopback forwarding and a TX launch FSM.
// Optional drop counter: define UART_FIFO_DROPCNT_EN.
module uart_fifo_bridge
    import uart_fifo_pkg::*;
#(
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      tx,
    input  logic                      mode,
    input  logic [UART_DW-1:0]        host_wdata,
    input  logic                      host_wr,
    output logic                      host_full,
    output logic [UART_DW-1:0]        host_rdata,
    input  logic                      host_rd,
    output logic                      host_empty,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic                      rx_overrun,
    input  logic                      clear,
    output logic [7:0]                drop_cnt
);
    logic               rx_done, tx_start, tx_busy;
    logic [UART_DW-1:0] rx_data, rx_head, tx_head, tx_wdata;
    logic               rx_full, rx_empty, tx_full, tx_empty;
    logic               rx_pop, tx_push, tx_pop, fwd, loop, drop;
    tx_state_e          state_q, state_d;
    logic [UART_DW-1:0] tx_data_q, tx_data_d;
    logic               rx_overrun_q, rx_overrun_d;

    // Forwarding moves one byte RX->TX atomically, so a mode flip never loses data.
    assign loop     = (mode == MODE_LOOPBACK);
    assign fwd      = loop && !rx_empty && !tx_full;
    assign rx_pop   = loop ? fwd : host_rd;
    assign tx_push  = loop ? fwd : host_wr;
    assign tx_wdata = loop ? rx_head : host_wdata;
    // A full RX FIFO is non-empty, so any pop request frees a slot this cycle.
    assign drop     = rx_done && rx_full && !rx_pop;

    assign host_rdata = rx_head;
    assign host_empty = rx_empty;
    assign host_full  = tx_full;
    assign rx_overrun = rx_overrun_q;

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(UART_DW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_done), .pop(rx_pop), .w_data(rx_data),
        .r_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(UART_DW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .w_data(tx_wdata),
        .r_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_start(tx_start),
        .tx_data(tx_data_q), .tx_busy(tx_busy), .rx_done(rx_done), .rx_data(rx_data)
    );

    // Sticky overrun; a clear in the same cycle as a drop wins.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (clear)     rx_overrun_d = 1'b0;
        else if (drop) rx_overrun_d = 1'b1;
    end

`ifdef UART_FIFO_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped RX bytes.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear)                           drop_cnt_d = '0;
        else if (drop && drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    // Launch FSM: pop a byte, pulse tx_start, then track one full busy window.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        tx_start  = 1'b0;
        case (state_q)
            TX_IDLE: if (!tx_empty && !tx_busy) begin
                tx_data_d = tx_head;
                tx_pop    = 1'b1;
                state_d   = TX_START;
            end
            TX_START: begin
                tx_start = 1'b1;
                state_d  = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: if (tx_busy)  state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
            default:                    state_d = TX_IDLE;
        endcase
    end

    // Control state, launch data and overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= TX_IDLE;
            tx_data_q    <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

endmodule
